// File: rtl/cpu_pkg.sv
// Shared EX-stage definitions: ALU select codes, multiply/divide op codes and
// the sequencer state encoding.
package cpu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic MD_MULTU = 1'b0;
    localparam logic MD_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } md_state_e;

endpackage

// File: rtl/alu32.sv
// 32-bit ripple-carry ALU. sel[2] inverts B and forces carry-in for subtract,
// so c_out_o=1 on subtract means "no borrow".
module alu32
    import cpu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  sel_i,
    input  logic        c_in_i,
    output logic [31:0] result_o,
    output logic        c_out_o
);

    logic [31:0] b_eff;
    logic [31:0] sum;
    logic [32:0] carry;

    always_comb begin
        b_eff    = sel_i[2] ? ~b_i : b_i;
        carry    = '0;
        carry[0] = sel_i[2] | c_in_i;
        sum      = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            sum[i]       = a_i[i] ^ b_eff[i] ^ carry[i];
            carry[i+1]   = (a_i[i] & b_eff[i]) | (carry[i] & (a_i[i] ^ b_eff[i]));
        end
    end

    assign c_out_o = carry[32];

    always_comb begin
        result_o = sum;
        case (sel_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = sum;
            ALU_SUB: result_o = sum;
            ALU_SLT: result_o = {31'b0, ~carry[32]};
            default: result_o = sum;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer: one alu32 add/subtract plus a
// shift per iteration, results committed to HI/LO on entry to FIN.
module muldiv_seq
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_q, init_d;
    logic             op_q, op_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] ph_q, ph_d;   // P_hi (MULTU) / R (DIVU)
    logic [WIDTH-1:0] pl_q, pl_d;   // P_lo (MULTU) / Q (DIVU)
    logic [WIDTH-1:0] m_q, m_d;     // M (MULTU) / D (DIVU)
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] alu_a, alu_sum;
    logic [2:0]       alu_sel;
    logic             alu_cout;
    logic [WIDTH-1:0] ph_step, pl_step;

    assign alu_a   = (op_q == MD_DIVU) ? {ph_q[WIDTH-2:0], pl_q[WIDTH-1]} : ph_q;
    assign alu_sel = (op_q == MD_DIVU) ? ALU_SUB : ALU_ADD;

    alu32 u_alu (
        .a_i      (alu_a),
        .b_i      (m_q),
        .sel_i    (alu_sel),
        .c_in_i   (1'b0),
        .result_o (alu_sum),
        .c_out_o  (alu_cout)
    );

    always_comb begin
        ph_step = ph_q;
        pl_step = pl_q;
        if (op_q == MD_DIVU) begin
            if (ph_q[WIDTH-1] || alu_cout) begin
                ph_step = alu_sum;
                pl_step = {pl_q[WIDTH-2:0], 1'b1};
            end else begin
                ph_step = alu_a;
                pl_step = {pl_q[WIDTH-2:0], 1'b0};
            end
        end else if (pl_q[0]) begin
            ph_step = {alu_cout, alu_sum[WIDTH-1:1]};
            pl_step = {alu_sum[0], pl_q[WIDTH-1:1]};
        end else begin
            ph_step = {1'b0, ph_q[WIDTH-1:1]};
            pl_step = {ph_q[0], pl_q[WIDTH-1:1]};
        end
    end

    // Every accepted op spends one setup cycle in RUN before iterating; the
    // divide-by-zero exit to FIN is taken from that cycle, so both paths share it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        op_d    = op_q;
        dbz_d   = 1'b0;
        ph_d    = ph_q;
        pl_d    = pl_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    op_d    = op;
                    ph_d    = '0;
                    pl_d    = (op == MD_DIVU) ? src_a : src_b;
                    m_d     = (op == MD_DIVU) ? src_b : src_a;
                    cnt_d   = '0;
                    init_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                init_d = 1'b0;
                if (cancel) begin
                    state_d = IDLE;
                end else if (init_q) begin
                    if (op_q == MD_DIVU && m_q == '0) begin
                        state_d = FIN;
                        hi_d    = pl_q;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                    end
                end else begin
                    ph_d  = ph_step;
                    pl_d  = pl_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = FIN;
                        hi_d    = ph_step;
                        lo_d    = pl_step;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            init_q  <= 1'b0;
            op_q    <= 1'b0;
            dbz_q   <= 1'b0;
            ph_q    <= '0;
            pl_q    <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            op_q    <= op_d;
            dbz_q   <= dbz_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written cancel/reset sequences.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;

    muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic, independent of the iteration scheme.
    function automatic vec_t model(input logic o, input logic [31:0] a, input logic [31:0] b);
        vec_t r;
        logic [63:0] prod;
        r.op = o; r.a = a; r.b = b; r.dbz = 1'b0; r.lat = 33;
        if (o == 1'b0) begin
            prod = {32'b0, a} * {32'b0, b};
            r.hi = prod[63:32];
            r.lo = prod[31:0];
        end else if (b == 32'd0) begin
            r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1; r.lat = 1;
        end else begin
            r.hi = a % b;
            r.lo = a / b;
        end
        return r;
    endfunction

    // Called at #1 after an edge with the DUT idle; returns #1 after the first idle edge.
    task automatic run_vec(input vec_t v, input string nm);
        int   lat;
        logic busy_ok;
        start = 1'b1; op = v.op; src_a = v.a; src_b = v.b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({nm, ".latency"}, 64'(lat), 64'(v.lat));
        check({nm, ".busy_run"}, 64'(busy_ok), 64'd1);
        check({nm, ".hi"}, 64'(hi), 64'(v.hi));
        check({nm, ".lo"}, 64'(lo), 64'(v.lo));
        check({nm, ".dbz"}, 64'(div_by_zero), 64'(v.dbz));
        @(posedge clk); #1;
        check({nm, ".idle_after"}, {62'b0, busy, done}, 64'd0);
    endtask

    initial begin
        int   dcount;
        vec_t v;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0; cancel = 1'b0;

        tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        tbl[1] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
        tbl[2] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 33};
        tbl[3] = '{1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};
        tbl[4] = '{1'b1, 32'h8000_0000, 32'd3,         32'd2,         32'h2AAA_AAAA, 1'b0, 33};
        tbl[5] = '{1'b0, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0, 33};
        tbl[6] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0, 33};
        tbl[7] = '{1'b1, 32'd7,         32'd9,         32'd7,         32'd0,         1'b0, 33};
        tbl[8] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 33};
        tbl[9] = '{1'b0, 32'h8000_0000, 32'd2,         32'd1,         32'd0,         1'b0, 33};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {28'b0, busy, done, div_by_zero, 1'b0, hi}, 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Consecutive entries also exercise back-to-back acceptance in the first idle cycle.
        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            logic        ro;
            logic [31:0] ra, rb;
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
            v = model(ro, ra, rb);
            run_vec(v, $sformatf("rand%0d", i));
        end

        // Divide by zero, whose result must survive the cancelled op below.
        v = model(1'b1, 32'd5, 32'd0);
        run_vec(v, "dbz");

        // MULTU cancelled mid-RUN; a start pulse during RUN must be ignored.
        start = 1'b1; op = 1'b0; src_a = 32'd12345; src_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (!busy || done) dcount++;
            start = (k == 5);
            if (k == 5) begin op = 1'b1; src_a = 32'd77; src_b = 32'd0; end
            cancel = (k == 10);
        end
        check("cancel.busy_before", 64'(dcount), 64'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel.idle", {62'b0, busy, done}, 64'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        check("cancel.no_done", 64'(dcount), 64'd0);
        check("cancel.hold", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

        // Cancel wins over start in IDLE.
        start = 1'b1; cancel = 1'b1; op = 1'b0; src_a = 32'd9; src_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("idle_cancel", 64'(busy), 64'd0);

        // Asynchronous reset mid-RUN clears outputs without waiting for an edge.
        start = 1'b1; op = 1'b0; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_busy", 64'(busy), 64'd1);
        #3 reset = 1'b1;
        #1;
        check("async_reset.ctl", {61'b0, busy, done, div_by_zero}, 64'd0);
        check("async_reset.hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        v = model(1'b0, 32'd3, 32'd4);
        run_vec(v, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
